// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back stage.
// Holds the buffer entry layout and the source-select encoding.
package wb_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 2;

    localparam logic [ADDR_W-1:0] ZERO_REG = 4'd0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam wb_entry_t EMPTY_ENTRY = '{valid: 1'b0, addr: 4'd0, data: 16'd0};

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_MEM  = 2'd3
    } wb_src_e;

    function automatic logic addr_hit(input wb_entry_t e, input logic [ADDR_W-1:0] a);
        return e.valid && (e.addr == a);
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry memory write buffer: push, pop, address-match invalidate with
// compaction. slot0 is the head (oldest), slot1 the tail (newest when full).
module wb_fifo2
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              nClear,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              inv,
    input  logic [ADDR_W-1:0] inv_addr,
    output logic [1:0]        count,
    output wb_entry_t         head,
    output wb_entry_t         tail
);

    wb_entry_t slot0_r;
    wb_entry_t slot1_r;
    wb_entry_t kept0_s;
    wb_entry_t kept1_s;
    wb_entry_t pack0_s;
    wb_entry_t pack1_s;
    wb_entry_t nxt0_s;
    wb_entry_t nxt1_s;
    wb_entry_t push_ent_s;

    assign push_ent_s = '{valid: 1'b1, addr: push_addr, data: push_data};

    // Remove entries: either the popped head or every entry hit by an ALU write.
    always_comb begin
        kept0_s = slot0_r;
        kept1_s = slot1_r;
        if (inv) begin
            kept0_s = addr_hit(slot0_r, inv_addr) ? EMPTY_ENTRY : slot0_r;
            kept1_s = addr_hit(slot1_r, inv_addr) ? EMPTY_ENTRY : slot1_r;
        end else if (pop) begin
            kept0_s = slot1_r;
            kept1_s = EMPTY_ENTRY;
        end else begin
            kept0_s = slot0_r;
            kept1_s = slot1_r;
        end
    end

    // A surviving tail slides into the head slot so slot0 is always the oldest.
    assign pack0_s = kept0_s.valid ? kept0_s : kept1_s;
    assign pack1_s = kept0_s.valid ? kept1_s : EMPTY_ENTRY;

    // Append the new write behind whatever survived.
    always_comb begin
        nxt0_s = pack0_s;
        nxt1_s = pack1_s;
        if (push && !pack0_s.valid) begin
            nxt0_s = push_ent_s;
        end else if (push) begin
            nxt1_s = push_ent_s;
        end else begin
            nxt0_s = pack0_s;
            nxt1_s = pack1_s;
        end
    end

    // Buffer storage.
    always_ff @(posedge clk) begin
        if (!nClear) begin
            slot0_r <= EMPTY_ENTRY;
            slot1_r <= EMPTY_ENTRY;
        end else begin
            slot0_r <= nxt0_s;
            slot1_r <= nxt1_s;
        end
    end

    assign count = {1'b0, slot0_r.valid} + {1'b0, slot1_r.valid};
    assign head  = slot0_r;
    assign tail  = slot1_r;

endmodule

// File: rtl/rf_writeback.sv
// Write-back arbiter (ALU over buffered memory loads) and operand bypass for
// the 16x16 register file. Define RF_WB_FWD_EN to forward pending writes.
module rf_writeback
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              nClear,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              wb_load,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    output logic              hazard
);

    logic [1:0]        fifo_count_s;
    wb_entry_t         fifo_head_s;
    wb_entry_t         fifo_tail_s;
    logic              alu_wr_s;
    logic              mem_wr_s;
    logic              mem_squash_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    wb_src_e           src_s;
    logic              wb_load_r;
    logic [ADDR_W-1:0] wb_addr_r;
    logic [DATA_W-1:0] wb_data_r;

    // Ready reflects the count at the start of the cycle; a same-cycle pop does not help.
    assign mem_ready    = nClear && (fifo_count_s < 2'(FIFO_DEPTH));
    assign alu_wr_s     = alu_valid && (alu_addr != ZERO_REG);
    assign mem_wr_s     = mem_valid && mem_ready && (mem_addr != ZERO_REG);
    assign mem_squash_s = alu_wr_s && (mem_addr == alu_addr);

    // Output-register source priority: ALU, buffered head, direct memory bypass.
    always_comb begin
        if (alu_wr_s) begin
            src_s = SRC_ALU;
        end else if (fifo_head_s.valid) begin
            src_s = SRC_FIFO;
        end else if (mem_wr_s) begin
            src_s = SRC_MEM;
        end else begin
            src_s = SRC_NONE;
        end
    end

    assign fifo_pop_s  = (src_s == SRC_FIFO);
    assign fifo_push_s = mem_wr_s && (src_s != SRC_MEM) && !mem_squash_s;

    wb_fifo2 u_fifo (
        .clk       (clk),
        .nClear    (nClear),
        .push      (fifo_push_s),
        .push_addr (mem_addr),
        .push_data (mem_data),
        .pop       (fifo_pop_s),
        .inv       (alu_wr_s),
        .inv_addr  (alu_addr),
        .count     (fifo_count_s),
        .head      (fifo_head_s),
        .tail      (fifo_tail_s)
    );

    // Register-file write port; address and data hold when no write is issued.
    always_ff @(posedge clk) begin
        if (!nClear) begin
            wb_load_r <= 1'b0;
            wb_addr_r <= 4'd0;
            wb_data_r <= 16'd0;
        end else begin
            case (src_s)
                SRC_ALU: begin
                    wb_load_r <= 1'b1;
                    wb_addr_r <= alu_addr;
                    wb_data_r <= alu_data;
                end
                SRC_FIFO: begin
                    wb_load_r <= 1'b1;
                    wb_addr_r <= fifo_head_s.addr;
                    wb_data_r <= fifo_head_s.data;
                end
                SRC_MEM: begin
                    wb_load_r <= 1'b1;
                    wb_addr_r <= mem_addr;
                    wb_data_r <= mem_data;
                end
                default: begin
                    wb_load_r <= 1'b0;
                end
            endcase
        end
    end

    assign wb_load = wb_load_r;
    assign wb_addr = wb_addr_r;
    assign wb_data = wb_data_r;

`ifdef RF_WB_FWD_EN
    function automatic logic [DATA_W-1:0] fwd_lookup(
        input logic [ADDR_W-1:0] r,
        input logic [DATA_W-1:0] rf_val,
        input wb_entry_t         tail_e,
        input wb_entry_t         head_e,
        input logic              ld,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (r == ZERO_REG) begin
            return 16'h0000;
        end else if (addr_hit(tail_e, r)) begin
            return tail_e.data;
        end else if (addr_hit(head_e, r)) begin
            return head_e.data;
        end else if (ld && (wa == r)) begin
            return wd;
        end else begin
            return rf_val;
        end
    endfunction

    assign opnd_a = fwd_lookup(rd_addr_a, rf_a, fifo_tail_s, fifo_head_s, wb_load_r, wb_addr_r, wb_data_r);
    assign opnd_b = fwd_lookup(rd_addr_b, rf_b, fifo_tail_s, fifo_head_s, wb_load_r, wb_addr_r, wb_data_r);
    assign hazard = 1'b0;
`else
    function automatic logic pending_hit(
        input logic [ADDR_W-1:0] r,
        input wb_entry_t         tail_e,
        input wb_entry_t         head_e,
        input logic              ld,
        input logic [ADDR_W-1:0] wa
    );
        return (r != ZERO_REG) &&
               (addr_hit(tail_e, r) || addr_hit(head_e, r) || (ld && (wa == r)));
    endfunction

    assign opnd_a = (rd_addr_a == ZERO_REG) ? 16'h0000 : rf_a;
    assign opnd_b = (rd_addr_b == ZERO_REG) ? 16'h0000 : rf_b;
    assign hazard = pending_hit(rd_addr_a, fifo_tail_s, fifo_head_s, wb_load_r, wb_addr_r) ||
                    pending_hit(rd_addr_b, fifo_tail_s, fifo_head_s, wb_load_r, wb_addr_r);
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Self-checking bench for rf_writeback: directed scenarios plus randomized
// traffic against a queue-based reference model of the write-back rules.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        nClear;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;
    logic        wb_load;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rf_a;
    logic [15:0] rf_b;
    logic [15:0] opnd_a;
    logic [15:0] opnd_b;
    logic        hazard;

    rf_writeback dut (
        .clk       (clk),
        .nClear    (nClear),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .wb_load   (wb_load),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rf_a      (rf_a),
        .rf_b      (rf_b),
        .opnd_a    (opnd_a),
        .opnd_b    (opnd_b),
        .hazard    (hazard)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } ent_t;

    // Reference model: pending memory writes oldest-first, plus the write port.
    ent_t        m_q[$];
    logic        m_load;
    logic [3:0]  m_addr;
    logic [15:0] m_data;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic exp_ready();
        return nClear && (m_q.size() < 2);
    endfunction

    function automatic logic [15:0] exp_opnd(input logic [3:0] r, input logic [15:0] rf);
        if (r == 4'd0) return 16'h0000;
`ifdef RF_WB_FWD_EN
        for (int i = m_q.size() - 1; i >= 0; i--)
            if (m_q[i].addr == r) return m_q[i].data;
        if (m_load && m_addr == r) return m_data;
`endif
        return rf;
    endfunction

    function automatic logic pending(input logic [3:0] r);
        if (r == 4'd0) return 1'b0;
        foreach (m_q[i]) if (m_q[i].addr == r) return 1'b1;
        return m_load && (m_addr == r);
    endfunction

    function automatic logic exp_hazard();
`ifdef RF_WB_FWD_EN
        return 1'b0;
`else
        return pending(rd_addr_a) || pending(rd_addr_b);
`endif
    endfunction

    task automatic model_update();
        logic mw;
        ent_t e;
        if (!nClear) begin
            m_q.delete();
            m_load = 1'b0;
            m_addr = 4'd0;
            m_data = 16'd0;
        end else begin
            mw = mem_valid && (m_q.size() < 2) && (mem_addr != 4'd0);
            e.addr = mem_addr;
            e.data = mem_data;
            if (alu_valid && alu_addr != 4'd0) begin
                for (int i = m_q.size() - 1; i >= 0; i--)
                    if (m_q[i].addr == alu_addr) m_q.delete(i);
                if (mw && mem_addr != alu_addr) m_q.push_back(e);
                m_load = 1'b1;
                m_addr = alu_addr;
                m_data = alu_data;
            end else if (m_q.size() > 0) begin
                ent_t h;
                h = m_q.pop_front();
                if (mw) m_q.push_back(e);
                m_load = 1'b1;
                m_addr = h.addr;
                m_data = h.data;
            end else if (mw) begin
                m_load = 1'b1;
                m_addr = mem_addr;
                m_data = mem_data;
            end else begin
                m_load = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        nClear = 1'b0; alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h5555;
        mem_valid = 1'b0; mem_addr = 4'd0; mem_data = 16'd0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0; rf_a = 16'd0; rf_b = 16'd0;
        tick();
        tick();
        #2;
        n_checks++;
        if ({wb_load, wb_addr, wb_data} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_wb: got %h %h %h, expected 0 0 0", wb_load, wb_addr, wb_data);
        end
        n_checks++;
        if (mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_low: got %b, expected 0", mem_ready);
        end
        nClear = 1'b1;
        alu_valid = 1'b0;
        #2;
        n_checks++;
        if (mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_release: got %b, expected 1", mem_ready);
        end
        tick();
    endtask

    task automatic test_alu_bypass();
        logic [15:0] exp_a;
        logic        exp_h;
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 16'h1234;
        tick();
        idle();
        rd_addr_a = 4'd5; rf_a = 16'h0000; rd_addr_b = 4'd0;
        #2;
        n_checks++;
        if ({wb_load, wb_addr, wb_data} !== {1'b1, 4'd5, 16'h1234}) begin
            n_fail++;
            $display("FAIL alu_write: got %b %h %h, expected 1 5 1234", wb_load, wb_addr, wb_data);
        end
`ifdef RF_WB_FWD_EN
        exp_a = 16'h1234; exp_h = 1'b0;
`else
        exp_a = 16'h0000; exp_h = 1'b1;
`endif
        n_checks++;
        if ({opnd_a, hazard} !== {exp_a, exp_h}) begin
            n_fail++;
            $display("FAIL alu_bypass_opnd: got %h/%b, expected %h/%b", opnd_a, hazard, exp_a, exp_h);
        end
        tick();
    endtask

    task automatic test_contention();
        int   k;
        ent_t offers[2];
        offers[0] = '{addr: 4'd7, data: 16'hAAAA};
        offers[1] = '{addr: 4'd8, data: 16'hBBBB};
        k = 0;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_addr  = 4'($urandom_range(10, 15));
            alu_data  = 16'($urandom);
            mem_valid = (k < 2);
            mem_addr  = offers[k % 2].addr;
            mem_data  = offers[k % 2].data;
            #2;
            n_checks++;
            if (mem_ready !== (i < 2)) begin
                n_fail++;
                $display("FAIL contention_ready[%0d]: got %b, expected %b", i, mem_ready, (i < 2));
            end
            if (mem_valid && exp_ready()) k++;
            tick();
            n_checks++;
            if ({wb_load, wb_addr, wb_data} !== {1'b1, alu_addr, alu_data}) begin
                n_fail++;
                $display("FAIL contention_alu[%0d]: got %b %h %h", i, wb_load, wb_addr, wb_data);
            end
        end
        idle();
        tick();
        n_checks++;
        if ({wb_load, wb_addr, wb_data} !== {1'b1, 4'd7, 16'hAAAA}) begin
            n_fail++;
            $display("FAIL drain_first: got %b %h %h, expected 1 7 aaaa", wb_load, wb_addr, wb_data);
        end
        tick();
        n_checks++;
        if ({wb_load, wb_addr, wb_data} !== {1'b1, 4'd8, 16'hBBBB}) begin
            n_fail++;
            $display("FAIL drain_second: got %b %h %h, expected 1 8 bbbb", wb_load, wb_addr, wb_data);
        end
        tick();
        n_checks++;
        if (wb_load !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_idle: got %b, expected 0", wb_load);
        end
    endtask

    task automatic test_squash();
        alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 16'($urandom);
        mem_valid = 1'b1; mem_addr = 4'd9; mem_data = 16'h1111;
        tick();
        mem_valid = 1'b0;
        alu_addr = 4'd9; alu_data = 16'h2222;
        tick();
        idle();
        n_checks++;
        if (dut.u_fifo.count !== 2'd0 || m_q.size() != 0) begin
            n_fail++;
            $display("FAIL squash_count: got %0d, expected 0", dut.u_fifo.count);
        end
        n_checks++;
        if ({wb_load, wb_addr, wb_data} !== {1'b1, 4'd9, 16'h2222}) begin
            n_fail++;
            $display("FAIL squash_write: got %b %h %h, expected 1 9 2222", wb_load, wb_addr, wb_data);
        end
        tick();
        n_checks++;
        if (wb_load !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_stale: got load=%b addr=%h data=%h, expected no write", wb_load, wb_addr, wb_data);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        mem_valid = 1'b1; mem_addr = 4'd0; mem_data = 16'hBEEF;
        rd_addr_b = 4'd0; rf_b = 16'hFFFF;
        #2;
        n_checks++;
        if (mem_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_handshake: got %b, expected 1", mem_ready);
        end
        n_checks++;
        if (opnd_b !== 16'h0000) begin
            n_fail++;
            $display("FAIL zero_read: got %h, expected 0000", opnd_b);
        end
        tick();
        mem_valid = 1'b0;
        n_checks++;
        if (wb_load !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_write: got %b, expected 0", wb_load);
        end
        tick();
    endtask

    task automatic test_fwd_macro();
        logic [15:0] exp_a;
        logic        exp_h;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'($urandom);
        mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 16'h00FF;
        tick();
        mem_valid = 1'b0;
        alu_addr = 4'd3;
        rd_addr_a = 4'd4; rf_a = 16'h1357; rd_addr_b = 4'd0;
        #2;
`ifdef RF_WB_FWD_EN
        exp_a = 16'h00FF; exp_h = 1'b0;
`else
        exp_a = 16'h1357; exp_h = 1'b1;
`endif
        n_checks++;
        if ({opnd_a, hazard} !== {exp_a, exp_h}) begin
            n_fail++;
            $display("FAIL fwd_pending: got %h/%b, expected %h/%b", opnd_a, hazard, exp_a, exp_h);
        end
        tick();
        idle();
        tick();
        tick();
    endtask

    task automatic test_random();
        logic [15:0] ea;
        logic [15:0] eb;
        for (int i = 0; i < 400; i++) begin
            nClear    = ($urandom_range(0, 39) != 0);
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_addr  = 4'($urandom_range(0, 7));
            alu_data  = 16'($urandom);
            mem_valid = ($urandom_range(0, 2) != 0);
            mem_addr  = 4'($urandom_range(0, 7));
            mem_data  = 16'($urandom);
            rd_addr_a = 4'($urandom_range(0, 7));
            rd_addr_b = 4'($urandom_range(0, 7));
            rf_a      = 16'($urandom);
            rf_b      = 16'($urandom);
            #2;
            ea = exp_opnd(rd_addr_a, rf_a);
            eb = exp_opnd(rd_addr_b, rf_b);
            n_checks++;
            if (mem_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b, expected %b", i, mem_ready, exp_ready());
            end
            n_checks++;
            if ({opnd_a, opnd_b} !== {ea, eb}) begin
                n_fail++;
                $display("FAIL rand_opnd[%0d]: got %h %h, expected %h %h", i, opnd_a, opnd_b, ea, eb);
            end
            n_checks++;
            if (hazard !== exp_hazard()) begin
                n_fail++;
                $display("FAIL rand_hazard[%0d]: got %b, expected %b", i, hazard, exp_hazard());
            end
            tick();
            n_checks++;
            if (wb_load !== m_load || (m_load && {wb_addr, wb_data} !== {m_addr, m_data})) begin
                n_fail++;
                $display("FAIL rand_wb[%0d]: got %b %h %h, expected %b %h %h",
                         i, wb_load, wb_addr, wb_data, m_load, m_addr, m_data);
            end
        end
        nClear = 1'b1;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_bypass();
        test_contention();
        test_squash();
        test_zero_reg();
        test_fwd_macro();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-back arbiter and operand bypass stage sitting directly upstream of the 16×16-bit register file. It merges two write sources into the file's single write port (C / Caddr / load):
- **ALU results:** these can never stall.
- **Memory-load completions:** these go through a 2-entry buffer with a valid/ready handshake.

On the read side it overlays pending writes onto the file's A/B read data, so consumers see the newest value. Register 0 is the hard-wired zero register: writes to it are dropped and reads of it return 0.

## Interface
Parameters (fixed by `wb_pkg`, not overridable):
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- FIFO_DEPTH, 2, memory write buffer entries

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- nClear  in  1  reset, synchronous, active-low: sampled on the rising edge of clk
- alu_valid  in  1  ALU write request this cycle
- alu_addr  in  4  ALU destination register
- alu_data  in  16  ALU result
- mem_valid  in  1  memory write offered
- mem_ready  out  1  buffer can accept a memory write
- mem_addr  in  4  memory destination register
- mem_data  in  16  memory load data
- wb_load  out  1  register file load; registered
- wb_addr  out  4  register file Caddr; registered
- wb_data  out  16  register file C; registered
- rd_addr_a  in  4  same address as register file Aaddr
- rd_addr_b  in  4  same address as register file Baddr
- rf_a  in  16  register file A output
- rf_b  in  16  register file B output
- opnd_a  out  16  corrected operand A; combinational
- opnd_b  out  16  corrected operand B; combinational
- hazard  out  1  read-after-write conflict that was not resolved; combinational

## Operation
**Reset (rising edge with nClear=0):**
- wb_load=0, wb_addr=0, wb_data=0.
- FIFO emptied.
- mem_ready=0 while nClear=0.
- mem_ready=1 in the first cycle after reset.

**Input filtering:**
- A request with address 0 is discarded.
- A memory request to address 0 still completes its handshake (it is consumed but never stored).

**Per-edge source select for the output register (priority order):**
1. alu_valid with address ≠0 → the ALU entry.
2. Otherwise, FIFO non-empty → the FIFO head, which is popped.
3. Otherwise, an accepted memory write → that write, bypassing the FIFO.
4. Otherwise → wb_load=0; wb_addr and wb_data hold their values.

**FIFO push:** an accepted memory write (mem_valid & mem_ready, address ≠0) that was not taken by the bypass in step 3.

**mem_ready:** equals (FIFO count < 2), evaluated on the count at the start of the cycle.
- A pop in the same cycle does not raise mem_ready (conservative).

**Ordering rule:** an ALU write is younger than every buffered or simultaneously arriving memory write. When a valid ALU write to X is selected:
- every FIFO entry with address X is invalidated, with the remaining entries compacted;
- a memory write to X accepted in the same cycle is consumed and dropped.

**Forwarding lookup for each read port, address r (newest first):**
1. r=0 → 0
2. FIFO tail entry
3. FIFO head entry
4. Output register (wb_load=1 and wb_addr=r)
5. rf_a / rf_b

## Timing
- **ALU write:** presented in cycle N → wb_load=1 in cycle N+1, and the register file captures it at the end of N+1.
- **Memory write, empty FIFO, no ALU request:** accepted in cycle N → wb_load=1 in cycle N+1.
- **Memory write while the ALU holds the port:** buffered, and written the first cycle the ALU is idle.
- **Back-to-back ALU writes:** one per cycle, indefinitely. The memory path starves but is never lost, because mem_ready stays low until the FIFO drains.
- **Forwarding path:** opnd_a, opnd_b and hazard are combinational from the current state and the rd_addr_a, rd_addr_b, rf_a and rf_b inputs. No added latency.
- **Reset mid-operation:** pending FIFO entries and the output register are discarded, with no write issued.

## Configuration
Macro: `RF_WB_FWD_EN`.
- **Defined:** the forwarding lookup drives opnd_a/opnd_b; hazard is tied 0.
- **Undefined:**
  - opnd_a=rf_a and opnd_b=rf_b, except that address 0 still reads 0;
  - hazard=1 whenever rd_addr_a or rd_addr_b is non-zero and matches a valid FIFO entry or the active output register;
  - the upstream pipeline stalls on hazard.

## Structure
- **`wb_pkg`:**
  - DATA_W, ADDR_W, FIFO_DEPTH;
  - ZERO_REG=4'd0;
  - typedef wb_entry_t {valid, addr[3:0], data[15:0]}.
- **Sub-module `wb_fifo2`:** 2-entry buffer providing push, pop, count, head/tail visibility, and address-match invalidate with compaction. The top level holds the arbitration, the output register and the forwarding logic.

## Test plan
- **Reset:** nClear=0 for 2 cycles with alu_valid=1, alu_addr=3 → wb_load=0, wb_addr=0, wb_data=0, mem_ready=0; mem_ready=1 in the first cycle after release.
- **ALU write and bypass:** ALU write of reg 5=0x1234 in cycle N → cycle N+1 has wb_load=1, wb_addr=5, wb_data=0x1234; with rd_addr_a=5, rf_a=0x0000, opnd_a=0x1234.
- **Contention and back-pressure:** ALU writes every cycle for 4 cycles while memory offers reg 7=0xAAAA then reg 8=0xBBBB:
  - both are accepted, then mem_ready=0;
  - after the ALU goes idle, reg 7 is written, then reg 8, in consecutive cycles.
- **Squash:** FIFO holds reg 9=0x1111, then an ALU write of reg 9=0x2222 → only 0x2222 is written to reg 9; the FIFO count drops to 0.
- **Zero register:** memory write of addr 0 with mem_valid=1 → handshake completes and wb_load stays 0; rd_addr_b=0 with rf_b=0xFFFF → opnd_b=0.
- **Forwarding macro:** pending FIFO write of reg 4=0x00FF with rd_addr_a=4:
  - RF_WB_FWD_EN defined → opnd_a=0x00FF, hazard=0;
  - undefined → opnd_a=rf_a, hazard=1.
